// File: rtl/debounce_pkg.sv
// Shared state encoding and defaults for the switch debouncer.
// Same two-bit encoding style as the edge-detector state constants.
package debounce_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } db_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 2000000;
  localparam int DEFAULT_CNT_WIDTH       = 21;

  // Bit 1 of the encoding is the debounced level, so the output is a plain flop bit.
  function automatic logic level_of(input db_state_t s);
    return s[1];
  endfunction

endpackage

// File: rtl/switch_debouncer_sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Both stages clear on the asynchronous active-high reset.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/switch_debouncer.sv
// Switch debouncer: Moore FSM with a stability down-counter feeding a clean level downstream.
// Define DEBOUNCE_SYNC_EN to insert a two-flop synchronizer on sw (adds two edges of latency).
module switch_debouncer
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_WIDTH       = DEFAULT_CNT_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic db_level
);

  localparam logic [CNT_WIDTH-1:0] RELOAD = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 sw_s;
  db_state_t            state_reg, state_next;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;

`ifdef DEBOUNCE_SYNC_EN
  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sw),
    .q     (sw_s)
  );
`else
  assign sw_s = sw;
`endif

  // A wait aborts on any opposite sample; re-entry always reloads the full window.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ZERO: begin
        if (sw_s) begin
          state_next = WAIT1;
          cnt_next   = RELOAD;
        end
      end
      WAIT1: begin
        if (!sw_s)
          state_next = ZERO;
        else if (cnt_reg == '0)
          state_next = ONE;
        else
          cnt_next = cnt_reg - CNT_WIDTH'(1);
      end
      ONE: begin
        if (!sw_s) begin
          state_next = WAIT0;
          cnt_next   = RELOAD;
        end
      end
      WAIT0: begin
        if (sw_s)
          state_next = ONE;
        else if (cnt_reg == '0)
          state_next = ZERO;
        else
          cnt_next = cnt_reg - CNT_WIDTH'(1);
      end
      default: state_next = ZERO;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ZERO;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign db_level = level_of(state_reg);

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer: directed vector table, corner sequences,
// and randomized bouncy input compared against a run-length reference model.
module tb_switch_debouncer;

  localparam int D = 4;
  localparam int W = 3;
`ifdef DEBOUNCE_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int L = D + SYNC_LAT;

  logic clk;
  logic reset;
  logic sw;
  logic db_level;

  int n_cmp = 0;
  int n_bad = 0;

  switch_debouncer #(
    .DEBOUNCE_CYCLES (D),
    .CNT_WIDTH       (W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sw       (sw),
    .db_level (db_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: level flips once D+1 consecutive samples disagree with it.
  bit m_level;
  int m_run;
  bit m_d1, m_d2;
  always @(posedge clk or posedge reset) begin
    bit s;
    if (reset) begin
      m_level = 1'b0;
      m_run   = 0;
      m_d1    = 1'b0;
      m_d2    = 1'b0;
    end else begin
      if (SYNC_LAT == 2) begin
        s    = m_d2;
        m_d2 = m_d1;
        m_d1 = sw;
      end else begin
        s = sw;
      end
      if (s != m_level) begin
        m_run = m_run + 1;
        if (m_run == D + 1) begin
          m_level = s;
          m_run   = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  end

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: db_level=%0b expected %0b at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: db_level=%0b", name, act);
    end
  endtask

  typedef struct {
    string name;
    bit    rst;
    bit    sw;
    int    n;
    bit    exp;
  } vec_t;

  vec_t vec[$];

  initial begin
    int hold;
    reset = 1'b1;
    sw    = 1'b0;

    vec.push_back('{"reset_hold",    1'b1, 1'b0, 2,     1'b0});
    vec.push_back('{"idle_zero",     1'b0, 1'b0, 3,     1'b0});
    vec.push_back('{"rise_before",   1'b0, 1'b1, L,     1'b0});
    vec.push_back('{"rise_after",    1'b0, 1'b1, 1,     1'b1});
    vec.push_back('{"hold_one",      1'b0, 1'b1, 3,     1'b1});
    vec.push_back('{"fall_before",   1'b0, 1'b0, L,     1'b1});
    vec.push_back('{"fall_after",    1'b0, 1'b0, 1,     1'b0});
    vec.push_back('{"bounce_high3",  1'b0, 1'b1, 3,     1'b0});
    vec.push_back('{"bounce_low1",   1'b0, 1'b0, 1,     1'b0});
    vec.push_back('{"bounce_before", 1'b0, 1'b1, L,     1'b0});
    vec.push_back('{"bounce_after",  1'b0, 1'b1, 1,     1'b1});
    vec.push_back('{"one_steady",    1'b0, 1'b1, 3,     1'b1});
    vec.push_back('{"fall_low2",     1'b0, 1'b0, 2,     1'b1});
    vec.push_back('{"glitch_high1",  1'b0, 1'b1, 1,     1'b1});
    vec.push_back('{"glitch_before", 1'b0, 1'b0, L,     1'b1});
    vec.push_back('{"glitch_after",  1'b0, 1'b0, 1,     1'b0});
    vec.push_back('{"pulse_high3",   1'b0, 1'b1, 3,     1'b0});
    vec.push_back('{"pulse_settle",  1'b0, 1'b0, L + 2, 1'b0});

    // Inputs change on the falling edge; outputs are checked there too.
    @(negedge clk);
    for (int i = 0; i < vec.size(); i++) begin
      reset = vec[i].rst;
      sw    = vec[i].sw;
      repeat (vec[i].n) @(negedge clk);
      check(vec[i].name, db_level, vec[i].exp);
    end

    // Reset in WAIT1 with two counts remaining, then full latency from scratch.
    sw = 1'b1;
    repeat (SYNC_LAT + 2) @(negedge clk);
    #2 reset = 1'b1;
    #1 check("rst_mid_wait", db_level, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (L) @(negedge clk);
    check("post_rst_before", db_level, 1'b0);
    @(negedge clk);
    check("post_rst_after", db_level, 1'b1);

    // Asynchronous reset from ONE must clear the level before the next clock edge.
    #2 reset = 1'b1;
    #1 check("async_rst_one", db_level, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    sw    = 1'b0;
    repeat (3) @(negedge clk);
    check("after_async_rst", db_level, 1'b0);

    // Randomized bouncy input with occasional resets against the reference model.
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        sw   = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 8);
      end
      hold--;
      reset = ($urandom_range(0, 299) == 0);
      @(negedge clk);
      n_cmp++;
      if (db_level !== m_level) begin
        n_bad++;
        $display("FAIL random[%0d]: db_level=%0b expected %0b at %0t", c, db_level, m_level, $time);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
